// File: rtl/pe_loader.sv
`default_nettype none
// ============================================================================
// Module   : pe_loader
// Purpose  : Upstream sequencer for one pe. Converts a single valid/ready
//            host word stream into the pe load protocol for each frame:
//              1. optional instruction burst (inst_in_v / inst_in),
//              2. gap-free data burst of 2*REG_NUM words (din_pe_v / din_pe),
//              3. timed run window of ITER_NUM iterations of ITER_LEN cycles,
//                 with alpha_v high during the final iteration.
//            Host stalls during data loading are absorbed by an internal
//            buffer, so the pe never sees a hole in din_pe_v.
//
// Ports    : clk        in   clock
//            rst        in   asynchronous active-low reset
//            start      in   frame start pulse, sampled only in IDLE
//            load_inst  in   sampled with start: 1 = program + data, 0 = data
//            s_valid    in   host word valid
//            s_ready    out  host word ready
//            s_data     in   host word (instruction or data), INST_WIDTH bits
//            inst_in_v  out  instruction valid to pe
//            inst_in    out  instruction to pe, INST_WIDTH bits
//            din_pe_v   out  data valid to pe
//            din_pe     out  data word to pe, 2*DATA_WIDTH bits
//            alpha_v    out  last-iteration flag to pe
//            busy       out  high in every state except IDLE
//            done       out  one-cycle end-of-frame pulse
//
// Notes    : INST_WIDTH must equal 2*DATA_WIDTH; the host word carries either
//            an instruction or a data word on the same bus.
//            REG_NUM >= 1 and ITER_NUM >= 1 are assumed.
//
// Revision : 1.0 - initial release
// ============================================================================
module pe_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int INST_WIDTH = 32,
  parameter int INST_NUM   = 16,
  parameter int REG_NUM    = 8,
  parameter int ITER_LEN   = 16,
  parameter int ITER_NUM   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    load_inst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [INST_WIDTH-1:0]   s_data,
  output logic                    inst_in_v,
  output logic [INST_WIDTH-1:0]   inst_in,
  output logic                    din_pe_v,
  output logic [2*DATA_WIDTH-1:0] din_pe,
  output logic                    alpha_v,
  output logic                    busy,
  output logic                    done
);

  // --------------------------------------------------------------------------
  // Derived sizes and terminal values
  // --------------------------------------------------------------------------
  localparam int c_DW2       = 2 * DATA_WIDTH;
  localparam int c_BURST_LEN = 2 * REG_NUM;
  localparam int c_IDX_W     = (c_BURST_LEN > 1) ? $clog2(c_BURST_LEN) : 1;
  // One extra pointer bit so that "full" (== c_BURST_LEN) is distinct from 0.
  localparam int c_PTR_W     = c_IDX_W + 1;
  localparam int c_RUN_LEN   = ITER_LEN * ITER_NUM;
  localparam int c_CNT_W     = $clog2(c_RUN_LEN + 1);
  localparam int c_ICNT_W    = $clog2(INST_NUM + 1);

  localparam logic [c_PTR_W-1:0]  c_PTR_FULL    = c_PTR_W'(c_BURST_LEN);
  localparam logic [c_PTR_W-1:0]  c_PTR_LAST    = c_PTR_W'(c_BURST_LEN - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST    = c_CNT_W'(c_RUN_LEN - 1);
  localparam logic [c_CNT_W-1:0]  c_ALPHA_START = c_CNT_W'((ITER_NUM - 1) * ITER_LEN);
  localparam logic [c_ICNT_W-1:0] c_INST_LAST   = c_ICNT_W'(INST_NUM - 1);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INST  = 3'd1,
    S_FILL  = 3'd2,
    S_BURST = 3'd3,
    S_RUN   = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Counters and pointers
  logic [c_ICNT_W-1:0] icnt_q, icnt_d;   // instruction handshakes this frame
  logic [c_PTR_W-1:0]  wptr_q, wptr_d;   // buffer write pointer
  logic [c_PTR_W-1:0]  rptr_q, rptr_d;   // buffer read pointer
  logic [c_CNT_W-1:0]  cnt_q,  cnt_d;    // run-window cycle counter

  // Registered pe-side outputs
  logic                  inst_in_v_q, inst_in_v_d;
  logic [INST_WIDTH-1:0] inst_in_q,   inst_in_d;
  logic                  din_pe_v_q,  din_pe_v_d;
  logic [c_DW2-1:0]      din_pe_q,    din_pe_d;

  // Data buffer (no reset: contents are always rewritten before being read)
  logic [c_DW2-1:0] mem_q [c_BURST_LEN];

  logic w_hs;       // host handshake this cycle
  logic w_mem_we;   // buffer write strobe
  logic w_rd_en;    // buffer read into din_pe register

  // --------------------------------------------------------------------------
  // Host-side ready. Purely a function of registered state, so it drops to 0
  // the moment reset is asserted (state goes to IDLE asynchronously).
  // --------------------------------------------------------------------------
  assign s_ready = (state_q == S_INST) ||
                   ((state_q == S_FILL) && (wptr_q < c_PTR_FULL));
  assign w_hs    = s_valid && s_ready;

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    icnt_d      = icnt_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    inst_in_v_d = 1'b0;
    inst_in_d   = inst_in_q;
    din_pe_v_d  = 1'b0;
    din_pe_d    = din_pe_q;
    w_mem_we    = 1'b0;
    w_rd_en     = 1'b0;
    alpha_v     = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          icnt_d  = '0;
          wptr_d  = '0;
          rptr_d  = '0;
          cnt_d   = '0;
          state_d = load_inst ? S_INST : S_FILL;
        end
      end

      // Instructions pass straight through with one cycle of latency; a host
      // stall simply produces a gap in inst_in_v.
      S_INST: begin
        if (w_hs) begin
          inst_in_v_d = 1'b1;
          inst_in_d   = s_data;
          icnt_d      = icnt_q + 1'b1;
          if (icnt_q == c_INST_LAST) begin
            wptr_d  = '0;
            rptr_d  = '0;
            state_d = S_FILL;
          end
        end
      end

      // Collect the whole data burst before releasing any of it, so the
      // burst towards the pe can be emitted without holes.
      S_FILL: begin
        if (w_hs) begin
          w_mem_we = 1'b1;
          wptr_d   = wptr_q + 1'b1;
          if (wptr_q == c_PTR_LAST) begin
            // Pre-load word 0 on the way out so din_pe_v is high in the
            // very first BURST cycle. Word 0 was written in an earlier
            // cycle, so reading it now is safe.
            w_rd_en = 1'b1;
            state_d = S_BURST;
          end
        end
      end

      // rptr_q counts words already presented; once all of them have been
      // shown (rptr_q == full) this is the last burst cycle.
      S_BURST: begin
        if (rptr_q == c_PTR_FULL) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          w_rd_en = 1'b1;
        end
      end

      // done is raised in the final run cycle, so a start presented in the
      // same cycle is seen outside IDLE and ignored.
      S_RUN: begin
        alpha_v = (cnt_q >= c_ALPHA_START);
        if (cnt_q == c_CNT_LAST) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_rd_en) begin
      din_pe_v_d = 1'b1;
      din_pe_d   = mem_q[rptr_q[c_IDX_W-1:0]];
      rptr_d     = rptr_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State, counters and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      icnt_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      inst_in_v_q <= 1'b0;
      inst_in_q   <= '0;
      din_pe_v_q  <= 1'b0;
      din_pe_q    <= '0;
    end else begin
      state_q     <= state_d;
      icnt_q      <= icnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      inst_in_v_q <= inst_in_v_d;
      inst_in_q   <= inst_in_d;
      din_pe_v_q  <= din_pe_v_d;
      din_pe_q    <= din_pe_d;
    end
  end

  // --------------------------------------------------------------------------
  // Data buffer write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem_q[wptr_q[c_IDX_W-1:0]] <= s_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign inst_in_v = inst_in_v_q;
  assign inst_in   = inst_in_q;
  assign din_pe_v  = din_pe_v_q;
  assign din_pe    = din_pe_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pe_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_loader
// Purpose  : Self-checking bench for pe_loader. A host-word queue is the
//            reference: each frame expects the first INST_NUM queued words as
//            instructions (when loading), the next 2*REG_NUM as the data
//            burst, and derives burst/run/alpha/done timing from frame rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_loader;

  localparam int DW       = 16;
  localparam int IW       = 32;
  localparam int INST_NUM = 4;
  localparam int REG_NUM  = 2;
  localparam int ITER_LEN = 3;
  localparam int ITER_NUM = 2;
  localparam int NDATA    = 2 * REG_NUM;
  localparam int RUN_LEN  = ITER_LEN * ITER_NUM;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          load_inst = 1'b0;
  logic          s_valid = 1'b0;
  logic [IW-1:0] s_data = '0;
  logic          s_ready;
  logic          inst_in_v;
  logic [IW-1:0] inst_in;
  logic          din_pe_v;
  logic [2*DW-1:0] din_pe;
  logic          alpha_v;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  logic [IW-1:0] host_q[$];

  always #5 clk = ~clk;

  pe_loader #(
    .DATA_WIDTH(DW),
    .INST_WIDTH(IW),
    .INST_NUM  (INST_NUM),
    .REG_NUM   (REG_NUM),
    .ITER_LEN  (ITER_LEN),
    .ITER_NUM  (ITER_NUM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_inst(load_inst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .inst_in_v(inst_in_v),
    .inst_in  (inst_in),
    .din_pe_v (din_pe_v),
    .din_pe   (din_pe),
    .alpha_v  (alpha_v),
    .busy     (busy),
    .done     (done)
  );

  task automatic push_words(input logic [IW-1:0] base, input int n);
    for (int i = 0; i < n; i++) host_q.push_back(base + IW'(i));
  endtask

  // Runs one frame from a start pulse to the cycle after done and checks it.
  // stall_mode: 0 = continuous host, 1 = fixed valid pattern during FILL,
  //             2 = random valid gaps. poke: extra start pulses in RUN/done.
  task automatic run_frame(input string name, input bit load, input int stall_mode, input bit poke);
    logic [IW-1:0] exp_inst[$];
    logic [IW-1:0] exp_data[$];
    logic [IW-1:0] got_inst[$];
    logic [IW-1:0] got_data[$];
    int inst_hs_cyc[$];
    int inst_v_cyc[$];
    int data_cyc[$];
    int alpha_cyc[$];
    int pattern[7];
    int ninst, consumed, cyc, pat, last_din, last_data_hs, done_cyc, bad_idx;
    bit hs, v, ready_leak, busy_drop;

    pattern = '{1, 0, 0, 1, 0, 1, 1};
    ninst = load ? INST_NUM : 0;
    consumed = 0; cyc = 0; pat = 0;
    last_din = -1; last_data_hs = -1; done_cyc = -1;
    ready_leak = 1'b0; busy_drop = 1'b0;
    for (int i = 0; i < ninst; i++) exp_inst.push_back(host_q[i]);
    for (int i = 0; i < NDATA; i++) exp_data.push_back(host_q[ninst + i]);

    while (done_cyc < 0 && cyc < 200) begin
      start = (cyc == 0);
      if (poke && last_din >= 0 && (cyc == last_din + 2 || cyc == last_din + RUN_LEN)) start = 1'b1;
      load_inst = load;
      v = (host_q.size() > 0);
      if (v && cyc > 0 && consumed < ninst + NDATA) begin
        if (stall_mode == 1 && consumed >= ninst) begin
          v = (pat < 7) ? pattern[pat][0] : 1'b1;
          pat++;
        end else if (stall_mode == 2) begin
          v = ($urandom_range(0, 2) != 0);
        end
      end
      s_valid = v;
      s_data  = v ? host_q[0] : IW'($urandom);
      #1;
      hs = s_valid && s_ready;
      if (hs && consumed < ninst) inst_hs_cyc.push_back(cyc);
      if (hs && consumed == ninst + NDATA - 1) last_data_hs = cyc;
      if (inst_in_v) begin got_inst.push_back(inst_in); inst_v_cyc.push_back(cyc); end
      if (din_pe_v) begin
        got_data.push_back(din_pe);
        data_cyc.push_back(cyc);
        if (data_cyc.size() == NDATA) last_din = cyc;
      end
      if (alpha_v) alpha_cyc.push_back(cyc);
      if (data_cyc.size() > 0 && s_ready) ready_leak = 1'b1;
      if (cyc > 0 && !busy) busy_drop = 1'b1;
      if (done) done_cyc = cyc;
      @(posedge clk); #1;
      if (hs) begin void'(host_q.pop_front()); consumed++; end
      cyc++;
    end
    start = 1'b0;
    #1;

    total++;
    if (done_cyc < 0) begin
      bad++; $display("FAIL %s done_timeout got no done within %0d cycles exp done", name, cyc);
    end

    total++;
    bad_idx = (got_inst.size() == ninst) ? -1 : 999;
    if (bad_idx < 0) foreach (got_inst[i]) if (bad_idx < 0 && got_inst[i] !== exp_inst[i]) bad_idx = i;
    if (bad_idx >= 0) begin
      bad++; $display("FAIL %s inst_stream got count=%0d (first bad idx %0d) exp count=%0d", name, got_inst.size(), bad_idx, ninst);
      if (bad_idx < got_inst.size() && bad_idx < ninst)
        $display("  %s inst word %0d got=%h exp=%h", name, bad_idx, got_inst[bad_idx], exp_inst[bad_idx]);
    end

    total++;
    bad_idx = (inst_v_cyc.size() == inst_hs_cyc.size()) ? -1 : 999;
    if (bad_idx < 0) foreach (inst_v_cyc[i]) if (bad_idx < 0 && inst_v_cyc[i] !== inst_hs_cyc[i] + 1) bad_idx = i;
    if (bad_idx >= 0) begin
      bad++; $display("FAIL %s inst_latency got %0d valid cycles (bad idx %0d) exp %0d, each one cycle after its handshake", name, inst_v_cyc.size(), bad_idx, inst_hs_cyc.size());
    end

    total++;
    bad_idx = (got_data.size() == NDATA) ? -1 : 999;
    if (bad_idx < 0) foreach (got_data[i]) if (bad_idx < 0 && got_data[i] !== exp_data[i]) bad_idx = i;
    if (bad_idx >= 0) begin
      bad++; $display("FAIL %s data_stream got count=%0d (first bad idx %0d) exp count=%0d", name, got_data.size(), bad_idx, NDATA);
      if (bad_idx < got_data.size() && bad_idx < NDATA)
        $display("  %s data word %0d got=%h exp=%h", name, bad_idx, got_data[bad_idx], exp_data[bad_idx]);
    end

    total++;
    if (data_cyc.size() != NDATA || data_cyc[NDATA-1] - data_cyc[0] != NDATA - 1) begin
      bad++; $display("FAIL %s burst_contiguous got %0d valid cycles exp %0d consecutive", name, data_cyc.size(), NDATA);
    end

    total++;
    if (data_cyc.size() == 0 || data_cyc[0] !== last_data_hs + 1) begin
      bad++; $display("FAIL %s burst_start got first din cycle=%0d exp=%0d", name, (data_cyc.size() > 0) ? data_cyc[0] : -1, last_data_hs + 1);
    end

    total++;
    if (done_cyc !== last_din + RUN_LEN) begin
      bad++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_cyc, last_din + RUN_LEN);
    end

    total++;
    if (alpha_cyc.size() != ITER_LEN || alpha_cyc[0] != last_din + 1 + (ITER_NUM - 1) * ITER_LEN ||
        alpha_cyc[ITER_LEN-1] != last_din + RUN_LEN) begin
      bad++; $display("FAIL %s alpha_window got count=%0d first=%0d exp count=%0d first=%0d", name, alpha_cyc.size(),
                      (alpha_cyc.size() > 0) ? alpha_cyc[0] : -1, ITER_LEN, last_din + 1 + (ITER_NUM - 1) * ITER_LEN);
    end

    total++;
    if (ready_leak !== 1'b0) begin
      bad++; $display("FAIL %s ready_in_burst_run got s_ready=1 during BURST/RUN exp 0", name);
    end

    total++;
    if (consumed !== ninst + NDATA) begin
      bad++; $display("FAIL %s words_consumed got=%0d exp=%0d", name, consumed, ninst + NDATA);
    end

    total++;
    if (busy_drop !== 1'b0) begin
      bad++; $display("FAIL %s busy_in_frame got busy=0 inside frame exp 1", name);
    end

    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL %s after_done got busy=%b done=%b exp busy=0 done=0", name, busy, done);
    end

    if (stall_mode == 0) begin
      total++;
      if (done_cyc !== ninst + 2 * NDATA + RUN_LEN) begin
        bad++; $display("FAIL %s frame_length got done at=%0d exp=%0d", name, done_cyc, ninst + 2 * NDATA + RUN_LEN);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({s_ready, inst_in_v, din_pe_v, alpha_v, busy, done} !== 6'b0 || inst_in !== '0 || din_pe !== '0) begin
      bad++; $display("FAIL reset_outputs got ctl=%b inst_in=%h din_pe=%h exp all 0",
                      {s_ready, inst_in_v, din_pe_v, alpha_v, busy, done}, inst_in, din_pe);
    end
    s_valid = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    host_q.delete();
    push_words(32'hA0, INST_NUM);
    push_words(32'hD0, NDATA);
    run_frame("basic", 1'b1, 0, 1'b0);
  endtask

  task automatic test_data_only();
    host_q.delete();
    push_words(32'hD0, NDATA);
    run_frame("data_only", 1'b0, 0, 1'b0);
  endtask

  task automatic test_host_stalls();
    host_q.delete();
    push_words(32'hB0, INST_NUM);
    push_words(32'hC0, NDATA);
    run_frame("stall_load", 1'b1, 1, 1'b0);
    push_words(32'hE0, NDATA);
    run_frame("stall_data", 1'b0, 1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int cyc, nd;
    bit hs, saw_done;
    host_q.delete();
    push_words(32'hA0, INST_NUM);
    push_words(32'hD0, NDATA);
    cyc = 0; nd = 0; saw_done = 1'b0;
    while (nd < 2 && cyc < 100) begin
      start = (cyc == 0);
      load_inst = 1'b1;
      s_valid = (host_q.size() > 0);
      s_data  = s_valid ? host_q[0] : '0;
      #1;
      hs = s_valid && s_ready;
      if (din_pe_v) nd++;
      if (done) saw_done = 1'b1;
      if (nd < 2) begin
        @(posedge clk); #1;
        if (hs) void'(host_q.pop_front());
        cyc++;
      end
    end
    start = 1'b0;
    total++;
    if (nd < 2) begin
      bad++; $display("FAIL rst_mid reach_burst got %0d burst cycles exp 2 within bound", nd);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({s_ready, inst_in_v, din_pe_v, alpha_v, busy, done} !== 6'b0 || inst_in !== '0 || din_pe !== '0) begin
      bad++; $display("FAIL rst_mid async_clear got ctl=%b inst_in=%h din_pe=%h exp all 0",
                      {s_ready, inst_in_v, din_pe_v, alpha_v, busy, done}, inst_in, din_pe);
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    if (done) saw_done = 1'b1;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    if (done) saw_done = 1'b1;
    total++;
    if (saw_done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid no_done got done_seen=%b busy=%b exp 0 0", saw_done, busy);
    end
    host_q.delete();
    push_words(32'hA0, INST_NUM);
    push_words(32'hD0, NDATA);
    run_frame("after_reset", 1'b1, 0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    host_q.delete();
    push_words(32'h10, INST_NUM);
    push_words(32'h20, NDATA);
    push_words(32'h30, NDATA);
    run_frame("start_poke", 1'b1, 0, 1'b1);
    run_frame("start_after_done", 1'b0, 0, 1'b0);
  endtask

  task automatic test_backpressure_hold();
    host_q.delete();
    push_words(32'hD0, NDATA);
    host_q.push_back(32'hEE);
    run_frame("bp_hold", 1'b0, 0, 1'b0);
    total++;
    if (host_q.size() != 1 || host_q[0] !== 32'hEE) begin
      bad++; $display("FAIL bp_hold held_word got queue size=%0d exp 1 word 000000ee", host_q.size());
    end
    push_words(32'hF0, NDATA - 1);
    run_frame("bp_next", 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    bit ld;
    for (int k = 0; k < 8; k++) begin
      ld = 1'($urandom_range(0, 1));
      host_q.delete();
      for (int i = 0; i < (ld ? INST_NUM : 0) + NDATA; i++) host_q.push_back(IW'($urandom));
      if ($urandom_range(0, 1) == 1) host_q.push_back(IW'($urandom));
      run_frame($sformatf("rand%0d", k), ld, 2, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_data_only();
    test_host_stalls();
    test_reset_mid_frame();
    test_start_while_busy();
    test_backpressure_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
